// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - decoder-side bus of the program sequencer
interface pc_seq_if #(
  parameter int AW    = 12,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic          enable;
  logic [2:0]    op;
  logic [AW-1:0] target;
  logic          irq;
  logic [AW-1:0] PCaddr;
  logic [SPW-1:0] sp;
  logic          stack_full;
  logic          stack_empty;
  logic          in_isr;
  logic          err;

  modport master (
    output enable, op, target, irq,
    input  PCaddr, sp, stack_full, stack_empty, in_isr, err
  );

  modport slave (
    input  enable, op, target, irq,
    output PCaddr, sp, stack_full, stack_empty, in_isr, err
  );
endinterface

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - program counter with skip/jump, return stack and single-level interrupt
module pc_seq #(
  parameter int AW         = 12,
  parameter int DEPTH      = 4,
  parameter int RESET_ADDR = 0,
  parameter int IRQ_VECTOR = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_seq_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0] RST_PC = AW'(RESET_ADDR);
  localparam logic [AW-1:0] IRQ_PC = AW'(IRQ_VECTOR);

  localparam logic [2:0] OP_INC    = 3'd0;
  localparam logic [2:0] OP_SKIP   = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_RESUME = 3'd5;

  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_ISR = 1'b1;

  logic [AW-1:0]  r_pc;
  logic [SPW-1:0] r_sp;
  logic [0:0]     r_state;
  logic [AW-1:0]  r_saved_pc;
  logic           r_err;
  logic [AW-1:0]  r_stack [0:DEPTH-1];

  logic [AW-1:0]  w_pc_next;
  logic [SPW-1:0] w_sp_next;
  logic [0:0]     w_state_next;
  logic [AW-1:0]  w_saved_next;
  logic           w_err_next;
  logic           w_push;
  logic           w_full;
  logic           w_empty;
  logic           w_take_irq;
  logic [IW-1:0]  w_push_idx;
  logic [IW-1:0]  w_top_idx;
  logic [AW-1:0]  w_ret_addr;
  logic [AW-1:0]  w_top;

  assign w_full     = (r_sp == SPW'(DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_take_irq = bus.enable && bus.irq && (r_state == ST_RUN);
  assign w_push_idx = IW'(r_sp);
  assign w_top_idx  = IW'(r_sp - SPW'(1));
  assign w_ret_addr = r_pc + AW'(1);
  assign w_top      = r_stack[w_top_idx];

  // Interrupt entry pre-empts the op entirely; the interrupted op re-executes on resume.
  always_comb begin
    w_pc_next    = r_pc;
    w_sp_next    = r_sp;
    w_state_next = r_state;
    w_saved_next = r_saved_pc;
    w_err_next   = r_err;
    w_push       = 1'b0;
    if (w_take_irq) begin
      w_saved_next = r_pc;
      w_pc_next    = IRQ_PC;
      w_state_next = ST_ISR;
    end else if (bus.enable) begin
      case (bus.op)
        OP_INC:  w_pc_next = r_pc + AW'(1);
        OP_SKIP: w_pc_next = r_pc + AW'(2);
        OP_JUMP: w_pc_next = bus.target;
        OP_CALL: begin
          if (w_full) begin
            w_err_next = 1'b1;
          end else begin
            w_push    = 1'b1;
            w_pc_next = bus.target;
            w_sp_next = r_sp + SPW'(1);
          end
        end
        OP_RET: begin
          if (w_empty) begin
            w_err_next = 1'b1;
          end else begin
            w_pc_next = w_top;
            w_sp_next = r_sp - SPW'(1);
          end
        end
        OP_RESUME: begin
          if (r_state == ST_ISR) begin
            w_pc_next    = r_saved_pc;
            w_state_next = ST_RUN;
          end else begin
            w_err_next = 1'b1;
          end
        end
        default: w_pc_next = r_pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RST_PC;
      r_sp       <= '0;
      r_state    <= ST_RUN;
      r_saved_pc <= '0;
      r_err      <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_sp       <= w_sp_next;
      r_state    <= w_state_next;
      r_saved_pc <= w_saved_next;
      r_err      <= w_err_next;
    end
  end

  // Stack contents need no reset; only sp defines which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_ret_addr;
    end
  end

  assign bus.PCaddr      = r_pc;
  assign bus.sp          = r_sp;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.in_isr      = (r_state == ST_ISR);
  assign bus.err         = r_err;
endmodule
